// File: rtl/load_store_unit_pkg.sv
// corePckg: shared types, widths, funct3 encodings and FSM states for the
// load/store unit. Ports: none (package).
package corePckg;

    localparam int unsigned cXLEN     = 32;
    localparam int unsigned cRegAddrW = 5;
    localparam int unsigned cBeW      = cXLEN / 8;

    // funct3 encodings shared by loads and stores
    localparam logic [2:0] cF3Byte  = 3'b000;
    localparam logic [2:0] cF3Half  = 3'b001;
    localparam logic [2:0] cF3Word  = 3'b010;
    localparam logic [2:0] cF3ByteU = 3'b100;
    localparam logic [2:0] cF3HalfU = 3'b101;

    typedef struct packed {
        logic [cXLEN-1:0]     addr;
        logic [cXLEN-1:0]     data;
        logic [2:0]           opType;
        logic [cRegAddrW-1:0] rdAddr;
        logic                 read;
        logic                 write;
    } tMemOp;

    typedef struct packed {
        logic                 dv;
        logic [cRegAddrW-1:0] addr;
        logic [cXLEN-1:0]     data;
    } tRegOp;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} tLsuState;

    // Encodings that are never legal, plus unsigned variants used as stores
    function automatic logic isIllegal(input logic read, input logic write,
                                       input logic [2:0] opType);
        logic badF3;
        logic badStore;
        badF3    = (opType == 3'b011) || (opType == 3'b110) || (opType == 3'b111);
        badStore = write && !((opType == cF3Byte) || (opType == cF3Half) ||
                              (opType == cF3Word));
        return (read && write) || badF3 || badStore;
    endfunction

    // Natural alignment check; requests with no access cannot be misaligned
    function automatic logic isMisaligned(input logic read, input logic write,
                                          input logic [2:0] opType,
                                          input logic [1:0] addrLo);
        logic mis;
        mis = 1'b0;
        if (read || write) begin
            case (opType[1:0])
                2'b01:   mis = addrLo[0];
                2'b10:   mis = (addrLo != 2'b00);
                default: mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// lsuIf: core request / data-memory / writeback bundle of the load/store unit.
// slave  = the LSU side, master = the core + memory environment.
interface lsuIf;
    import corePckg::*;

    logic                 iMemValid;
    logic                 oMemReady;
    tMemOp                iMemOp;
    logic                 oDmemReq;
    logic                 oDmemWe;
    logic [cXLEN-1:0]     oDmemAddr;
    logic [cXLEN-1:0]     oDmemWdata;
    logic [cBeW-1:0]      oDmemBe;
    logic                 iDmemGnt;
    logic                 iDmemRvalid;
    logic [cXLEN-1:0]     iDmemRdata;
    tRegOp                oRegOp;
    logic                 oFault;

    modport slave (
        input  iMemValid, iMemOp, iDmemGnt, iDmemRvalid, iDmemRdata,
        output oMemReady, oDmemReq, oDmemWe, oDmemAddr, oDmemWdata, oDmemBe,
               oRegOp, oFault
    );

    modport master (
        output iMemValid, iMemOp, iDmemGnt, iDmemRvalid, iDmemRdata,
        input  oMemReady, oDmemReq, oDmemWe, oDmemAddr, oDmemWdata, oDmemBe,
               oRegOp, oFault
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsuLaneAlign: combinational byte-lane steering for stores and
// extraction/extension for loads.
// Ports: opType, addrLo, isStore, storeData, loadWord in;
//        be_c, wdata_c, loadData_c out (combinational).
module lsuLaneAlign
    import corePckg::*;
(
    input  logic [2:0]       opType,
    input  logic [1:0]       addrLo,
    input  logic             isStore,
    input  logic [cXLEN-1:0] storeData,
    input  logic [cXLEN-1:0] loadWord,
    output logic [cBeW-1:0]  be_c,
    output logic [cXLEN-1:0] wdata_c,
    output logic [cXLEN-1:0] loadData_c
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Store lanes: loads keep all four enables
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = storeData;
        if (isStore) begin
            case (opType)
                cF3Byte: begin
                    be_c    = 4'(4'b0001 << addrLo);
                    wdata_c = {4{storeData[7:0]}};
                end
                cF3Half: begin
                    be_c    = addrLo[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{storeData[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = storeData;
                end
            endcase
        end
    end

    // Load extraction with sign/zero extension
    always_comb begin
        case (addrLo)
            2'd0:    byteSel = loadWord[7:0];
            2'd1:    byteSel = loadWord[15:8];
            2'd2:    byteSel = loadWord[23:16];
            default: byteSel = loadWord[31:24];
        endcase
        halfSel = addrLo[1] ? loadWord[31:16] : loadWord[15:0];
        case (opType)
            cF3Byte:  loadData_c = {{24{byteSel[7]}}, byteSel};
            cF3ByteU: loadData_c = {24'd0, byteSel};
            cF3Half:  loadData_c = {{16{halfSel[15]}}, halfSel};
            cF3HalfU: loadData_c = {16'd0, halfSel};
            default:  loadData_c = loadWord;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between the core and
// a req/gnt/rvalid data memory. FSM IDLE -> REQ -> WAIT -> (WB) -> IDLE.
// Ports: iClk, iRst (sync, active-low), bus (lsuIf.slave: request in,
//        dmem request/response, register writeback, fault pulse).
module load_store_unit #(
    parameter int unsigned cXLEN = 32
) (
    input logic iClk,
    input logic iRst,
    lsuIf.slave bus
);
    import corePckg::*;

    tLsuState         stateQ, stateD;
    logic             memReadyQ, memReadyD;
    logic             dmemReqQ, dmemReqD;
    logic             dmemWeQ, dmemWeD;
    logic [cXLEN-1:0] dmemAddrQ, dmemAddrD;
    logic [cXLEN-1:0] dmemWdataQ, dmemWdataD;
    logic [3:0]       dmemBeQ, dmemBeD;
    logic             faultQ, faultD;
    tRegOp            regOpQ, regOpD;
    logic [2:0]       opTypeQ, opTypeD;
    logic [1:0]       addrLoQ, addrLoD;
    logic [4:0]       rdAddrQ, rdAddrD;

    logic [2:0]       alignOpType;
    logic [1:0]       alignAddrLo;
    logic             alignStore;
    logic [3:0]       be_c;
    logic [cXLEN-1:0] wdata_c;
    logic [cXLEN-1:0] loadData_c;

    // Steer from the incoming request while idle, from the captured one after
    assign alignOpType = (stateQ == IDLE) ? bus.iMemOp.opType     : opTypeQ;
    assign alignAddrLo = (stateQ == IDLE) ? bus.iMemOp.addr[1:0]  : addrLoQ;
    assign alignStore  = (stateQ == IDLE) ? bus.iMemOp.write      : dmemWeQ;

    lsuLaneAlign uLaneAlign (
        .opType     (alignOpType),
        .addrLo     (alignAddrLo),
        .isStore    (alignStore),
        .storeData  (bus.iMemOp.data),
        .loadWord   (bus.iDmemRdata),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .loadData_c (loadData_c)
    );

    // State and output registers
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            stateQ     <= IDLE;
            memReadyQ  <= 1'b0;
            dmemReqQ   <= 1'b0;
            dmemWeQ    <= 1'b0;
            dmemAddrQ  <= '0;
            dmemWdataQ <= '0;
            dmemBeQ    <= '0;
            faultQ     <= 1'b0;
            regOpQ     <= '0;
            opTypeQ    <= '0;
            addrLoQ    <= '0;
            rdAddrQ    <= '0;
        end else begin
            stateQ     <= stateD;
            memReadyQ  <= memReadyD;
            dmemReqQ   <= dmemReqD;
            dmemWeQ    <= dmemWeD;
            dmemAddrQ  <= dmemAddrD;
            dmemWdataQ <= dmemWdataD;
            dmemBeQ    <= dmemBeD;
            faultQ     <= faultD;
            regOpQ     <= regOpD;
            opTypeQ    <= opTypeD;
            addrLoQ    <= addrLoD;
            rdAddrQ    <= rdAddrD;
        end
    end

    // Next state and next output values
    always_comb begin
        stateD     = stateQ;
        dmemReqD   = dmemReqQ;
        dmemWeD    = dmemWeQ;
        dmemAddrD  = dmemAddrQ;
        dmemWdataD = dmemWdataQ;
        dmemBeD    = dmemBeQ;
        faultD     = 1'b0;
        regOpD     = '0;
        opTypeD    = opTypeQ;
        addrLoD    = addrLoQ;
        rdAddrD    = rdAddrQ;

        case (stateQ)
            IDLE: begin
                if (bus.iMemValid && memReadyQ) begin
                    if (isIllegal(bus.iMemOp.read, bus.iMemOp.write, bus.iMemOp.opType) ||
                        isMisaligned(bus.iMemOp.read, bus.iMemOp.write,
                                     bus.iMemOp.opType, bus.iMemOp.addr[1:0])) begin
                        faultD = 1'b1;
                    end else if (bus.iMemOp.read || bus.iMemOp.write) begin
                        stateD     = REQ;
                        dmemReqD   = 1'b1;
                        dmemWeD    = bus.iMemOp.write;
                        dmemAddrD  = {bus.iMemOp.addr[cXLEN-1:2], 2'b00};
                        dmemWdataD = wdata_c;
                        dmemBeD    = be_c;
                        opTypeD    = bus.iMemOp.opType;
                        addrLoD    = bus.iMemOp.addr[1:0];
                        rdAddrD    = bus.iMemOp.rdAddr;
                    end
                end
            end
            REQ: begin
                if (bus.iDmemGnt) begin
                    stateD   = WAIT;
                    dmemReqD = 1'b0;
                end
            end
            WAIT: begin
                if (bus.iDmemRvalid) begin
                    if (dmemWeQ) begin
                        stateD = IDLE;
                    end else begin
                        // x0 writes are suppressed but still pass through WB
                        stateD      = WB;
                        regOpD.dv   = (rdAddrQ != 5'd0);
                        regOpD.addr = rdAddrQ;
                        regOpD.data = loadData_c;
                    end
                end
            end
            WB:      stateD = IDLE;
            default: stateD = IDLE;
        endcase

        memReadyD = (stateD == IDLE);
    end

    assign bus.oMemReady  = memReadyQ;
    assign bus.oDmemReq   = dmemReqQ;
    assign bus.oDmemWe    = dmemWeQ;
    assign bus.oDmemAddr  = dmemAddrQ;
    assign bus.oDmemWdata = dmemWdataQ;
    assign bus.oDmemBe    = dmemBeQ;
    assign bus.oFault     = faultQ;
    assign bus.oRegOp     = regOpQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus a
// randomized run checked against a behavioural model.
module tb_load_store_unit;
    import corePckg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lsuIf bus ();

    load_store_unit #(.cXLEN(32)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        readyBefore;
        logic        fault;
        logic        readyAt;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        stable;
        logic        reqDropped;
        logic        earlyDv;
        logic        dv;
        logic [4:0]  dvAddr;
        logic [31:0] dvData;
        int          latency;
        logic        readyAfter;
        logic        dvAfter;
        logic        readyEnd;
    } tObs;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    function automatic int accessBytes(input logic [2:0] f3);
        int sz;
        sz = int'(f3) % 4;
        return 1 << sz;
    endfunction

    function automatic logic modelFault(input tMemOp op);
        int f3;
        f3 = int'(op.opType);
        if (op.read && op.write) return 1'b1;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (op.write && f3 > 2) return 1'b1;
        if ((op.read || op.write) && (int'(op.addr % 4) % accessBytes(op.opType)) != 0)
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] modelBe(input tMemOp op);
        int n;
        int ofs;
        if (!op.write) return 4'hF;
        n   = accessBytes(op.opType);
        ofs = int'(op.addr % 4);
        return 4'(((1 << n) - 1) << ofs);
    endfunction

    function automatic logic [31:0] modelWdata(input tMemOp op);
        case (accessBytes(op.opType))
            1:       return (op.data & 32'hFF) * 32'h0101_0101;
            2:       return (op.data & 32'hFFFF) * 32'h0001_0001;
            default: return op.data;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input tMemOp op, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * int'(op.addr % 4));
        case (int'(op.opType))
            0:       return 32'($signed(v[7:0]));
            4:       return v & 32'hFF;
            1:       return 32'($signed(v[15:0]));
            5:       return v & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    // ---------------- transaction driver (observes, does not judge) --------
    task automatic runAccess(input tMemOp op, input int gntDelay, input int rvDelay,
                             input logic [31:0] rdata, output tObs o);
        int cyc;
        o = '{default: 0};
        for (int i = 0; i < 8 && bus.oMemReady !== 1'b1; i++) tick();
        o.readyBefore = bus.oMemReady;
        bus.iMemOp    = op;
        bus.iMemValid = 1'b1;
        tick();
        bus.iMemValid = 1'b0;
        cyc       = 1;
        o.fault   = bus.oFault;
        o.readyAt = bus.oMemReady;
        o.req     = bus.oDmemReq;
        o.we      = bus.oDmemWe;
        o.addr    = bus.oDmemAddr;
        o.wdata   = bus.oDmemWdata;
        o.be      = bus.oDmemBe;
        if (o.req !== 1'b1) return;
        o.stable = 1'b1;
        for (int i = 0; i < gntDelay; i++) begin
            tick();
            cyc++;
            if (bus.oDmemReq !== 1'b1 || bus.oDmemWe !== o.we || bus.oDmemAddr !== o.addr ||
                bus.oDmemWdata !== o.wdata || bus.oDmemBe !== o.be)
                o.stable = 1'b0;
            if (bus.oRegOp.dv !== 1'b0) o.earlyDv = 1'b1;
        end
        bus.iDmemGnt = 1'b1;
        tick();
        cyc++;
        bus.iDmemGnt = 1'b0;
        o.reqDropped = (bus.oDmemReq === 1'b0);
        if (bus.oRegOp.dv !== 1'b0) o.earlyDv = 1'b1;
        for (int i = 0; i < rvDelay; i++) begin
            tick();
            cyc++;
            if (bus.oRegOp.dv !== 1'b0) o.earlyDv = 1'b1;
        end
        bus.iDmemRvalid = 1'b1;
        bus.iDmemRdata  = rdata;
        tick();
        cyc++;
        bus.iDmemRvalid = 1'b0;
        bus.iDmemRdata  = $urandom;
        o.dv         = bus.oRegOp.dv;
        o.dvAddr     = bus.oRegOp.addr;
        o.dvData     = bus.oRegOp.data;
        o.latency    = cyc;
        o.readyAfter = bus.oMemReady;
        tick();
        o.dvAfter  = bus.oRegOp.dv;
        o.readyEnd = bus.oMemReady;
    endtask

    function automatic tMemOp mkOp(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [2:0] f3, input logic [4:0] rd,
                                   input logic rd_en, input logic wr_en);
        tMemOp op;
        op.addr = addr; op.data = data; op.opType = f3; op.rdAddr = rd;
        op.read = rd_en; op.write = wr_en;
        return op;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        total++; if (bus.oMemReady !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.oMemReady); end
        total++; if (bus.oDmemReq !== 1'b0 || bus.oDmemWe !== 1'b0) begin bad++; $display("FAIL reset_req got=%b/%b exp=0/0", bus.oDmemReq, bus.oDmemWe); end
        total++; if (bus.oFault !== 1'b0 || bus.oRegOp !== '0) begin bad++; $display("FAIL reset_fault_regop got=%b/%h exp=0/0", bus.oFault, bus.oRegOp); end
        total++; if (bus.oDmemAddr !== 32'd0 || bus.oDmemWdata !== 32'd0 || bus.oDmemBe !== 4'd0) begin bad++; $display("FAIL reset_bus got=%h/%h/%b exp=0", bus.oDmemAddr, bus.oDmemWdata, bus.oDmemBe); end
        rst = 1'b1;
        tick();
        total++; if (bus.oMemReady !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", bus.oMemReady); end
    endtask

    task automatic test_store_word();
        tObs o;
        runAccess(mkOp(32'h100, 32'hDEADBEEF, cF3Word, 5'd3, 1'b0, 1'b1), 0, 0, 32'h0, o);
        total++; if (o.req !== 1'b1 || o.we !== 1'b1) begin bad++; $display("FAIL sw_req got=%b/%b exp=1/1", o.req, o.we); end
        total++; if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_bus got=%h/%b/%h exp=100/1111/deadbeef", o.addr, o.be, o.wdata); end
        total++; if (o.readyAt !== 1'b0 || o.reqDropped !== 1'b1) begin bad++; $display("FAIL sw_handshake ready=%b dropped=%b exp=0/1", o.readyAt, o.reqDropped); end
        total++; if (o.dv !== 1'b0 || o.earlyDv !== 1'b0 || o.readyAfter !== 1'b1) begin bad++; $display("FAIL sw_done dv=%b early=%b ready=%b exp=0/0/1", o.dv, o.earlyDv, o.readyAfter); end
    endtask

    task automatic test_store_lanes();
        tObs o;
        runAccess(mkOp(32'h102, 32'h12345678, cF3Byte, 5'd0, 1'b0, 1'b1), 0, 0, 32'h0, o);
        total++; if (o.be !== 4'b0100 || o.wdata !== 32'h78787878) begin bad++; $display("FAIL sb_lanes got=%b/%h exp=0100/78787878", o.be, o.wdata); end
        runAccess(mkOp(32'h102, 32'h12345678, cF3Half, 5'd0, 1'b0, 1'b1), 1, 1, 32'h0, o);
        total++; if (o.be !== 4'b1100 || o.wdata !== 32'h56785678 || o.addr !== 32'h100) begin bad++; $display("FAIL sh_lanes got=%b/%h/%h exp=1100/56785678/100", o.be, o.wdata, o.addr); end
    endtask

    task automatic test_load_byte();
        tObs o;
        runAccess(mkOp(32'h203, 32'h0, cF3Byte, 5'd5, 1'b1, 1'b0), 0, 0, 32'h80FFFFFF, o);
        total++; if (o.addr !== 32'h200 || o.we !== 1'b0 || o.be !== 4'b1111) begin bad++; $display("FAIL lb_bus got=%h/%b/%b exp=200/0/1111", o.addr, o.we, o.be); end
        total++; if (o.dv !== 1'b1 || o.dvAddr !== 5'd5 || o.dvData !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_wb got=%b/%0d/%h exp=1/5/ffffff80", o.dv, o.dvAddr, o.dvData); end
        total++; if (o.latency !== 3 || o.dvAfter !== 1'b0 || o.readyEnd !== 1'b1) begin bad++; $display("FAIL lb_timing lat=%0d dvAfter=%b ready=%b exp=3/0/1", o.latency, o.dvAfter, o.readyEnd); end
    endtask

    task automatic test_load_half_unsigned();
        tObs o;
        runAccess(mkOp(32'h102, 32'h0, cF3HalfU, 5'd9, 1'b1, 1'b0), 0, 0, 32'hABCD1234, o);
        total++; if (o.dv !== 1'b1 || o.dvData !== 32'h0000ABCD) begin bad++; $display("FAIL lhu_data got=%b/%h exp=1/0000abcd", o.dv, o.dvData); end
    endtask

    task automatic test_fault();
        tObs o;
        runAccess(mkOp(32'h101, 32'h1, cF3Half, 5'd0, 1'b0, 1'b1), 0, 0, 32'h0, o);
        total++; if (o.fault !== 1'b1 || o.req !== 1'b0 || o.readyAt !== 1'b1) begin bad++; $display("FAIL sh_misaligned fault=%b req=%b ready=%b exp=1/0/1", o.fault, o.req, o.readyAt); end
        tick();
        total++; if (bus.oFault !== 1'b0 || bus.oDmemReq !== 1'b0) begin bad++; $display("FAIL fault_pulse fault=%b req=%b exp=0/0", bus.oFault, bus.oDmemReq); end
    endtask

    task automatic test_drop();
        tObs o;
        runAccess(mkOp(32'h301, 32'h5, cF3Word, 5'd4, 1'b0, 1'b0), 0, 0, 32'h0, o);
        total++; if (o.fault !== 1'b0 || o.req !== 1'b0 || o.readyAt !== 1'b1) begin bad++; $display("FAIL drop fault=%b req=%b ready=%b exp=0/0/1", o.fault, o.req, o.readyAt); end
    endtask

    task automatic test_gnt_stall();
        tObs o;
        runAccess(mkOp(32'h440, 32'h0, cF3Word, 5'd7, 1'b1, 1'b0), 5, 0, 32'h13572468, o);
        total++; if (o.stable !== 1'b1 || o.earlyDv !== 1'b0) begin bad++; $display("FAIL lw_stall stable=%b early=%b exp=1/0", o.stable, o.earlyDv); end
        total++; if (o.dv !== 1'b1 || o.dvData !== 32'h13572468 || o.latency !== 8) begin bad++; $display("FAIL lw_stall_wb dv=%b data=%h lat=%0d exp=1/13572468/8", o.dv, o.dvData, o.latency); end
    endtask

    task automatic test_rd_zero();
        tObs o;
        runAccess(mkOp(32'h10, 32'h0, cF3Word, 5'd0, 1'b1, 1'b0), 0, 0, 32'hCAFEF00D, o);
        total++; if (o.dv !== 1'b0 || o.readyAfter !== 1'b0 || o.readyEnd !== 1'b1) begin bad++; $display("FAIL rd_zero dv=%b readyWB=%b readyEnd=%b exp=0/0/1", o.dv, o.readyAfter, o.readyEnd); end
    endtask

    task automatic test_reset_in_wait();
        bus.iMemOp    = mkOp(32'h500, 32'h0, cF3Word, 5'd6, 1'b1, 1'b0);
        bus.iMemValid = 1'b1;
        tick();
        bus.iMemValid = 1'b0;
        bus.iDmemGnt  = 1'b1;
        tick();
        bus.iDmemGnt  = 1'b0;
        rst = 1'b0;
        tick();
        total++; if (bus.oMemReady !== 1'b0 || bus.oDmemReq !== 1'b0 || bus.oDmemAddr !== 32'd0 || bus.oDmemBe !== 4'd0) begin bad++; $display("FAIL rst_wait_regs ready=%b req=%b addr=%h be=%b exp=0/0/0/0", bus.oMemReady, bus.oDmemReq, bus.oDmemAddr, bus.oDmemBe); end
        rst = 1'b1;
        bus.iDmemRvalid = 1'b1;
        bus.iDmemRdata  = 32'h11112222;
        tick();
        bus.iDmemRvalid = 1'b0;
        total++; if (bus.oRegOp.dv !== 1'b0 || bus.oMemReady !== 1'b1) begin bad++; $display("FAIL rst_wait_late_rvalid dv=%b ready=%b exp=0/1", bus.oRegOp.dv, bus.oMemReady); end
        tick();
        total++; if (bus.oRegOp.dv !== 1'b0 || bus.oDmemReq !== 1'b0) begin bad++; $display("FAIL rst_wait_after dv=%b req=%b exp=0/0", bus.oRegOp.dv, bus.oDmemReq); end
    endtask

    task automatic test_random();
        tObs         o;
        tMemOp       op;
        logic [31:0] rdata;
        logic        expFault;
        logic        expAccess;
        logic        expDv;
        int          gd;
        int          rv;
        int          kind;
        int          t;
        for (int n = 0; n < 60; n++) begin
            op.addr   = $urandom;
            if ($urandom_range(0, 1) == 1) op.addr[1:0] = 2'b00;
            op.data   = $urandom;
            op.rdAddr = 5'($urandom_range(0, 31));
            op.opType = 3'($urandom_range(0, 7));
            kind      = int'($urandom_range(0, 9));
            op.read   = 1'b0;
            op.write  = 1'b0;
            if (kind == 0) begin
                t = int'($urandom_range(0, 4));
                op.opType = (t < 3) ? 3'(t) : 3'(t + 1);
            end else if (kind == 1) begin
                op.read = 1'b1; op.write = 1'b1;
            end else if (kind < 6) begin
                op.read = 1'b1;
            end else begin
                op.write = 1'b1;
            end
            rdata = $urandom;
            gd    = int'($urandom_range(0, 3));
            rv    = int'($urandom_range(0, 2));
            runAccess(op, gd, rv, rdata, o);

            expFault  = modelFault(op);
            expAccess = !expFault && (op.read || op.write);
            expDv     = expAccess && op.read && (op.rdAddr != 5'd0);
            total++; if (o.readyBefore !== 1'b1 || o.fault !== expFault || o.req !== expAccess) begin bad++; $display("FAIL rnd%0d_class ready=%b fault=%b req=%b exp=1/%b/%b", n, o.readyBefore, o.fault, o.req, expFault, expAccess); end
            if (expAccess) begin
                total++; if (o.we !== op.write || o.addr !== (op.addr & 32'hFFFF_FFFC) || o.be !== modelBe(op)) begin bad++; $display("FAIL rnd%0d_bus we=%b addr=%h be=%b exp=%b/%h/%b", n, o.we, o.addr, o.be, op.write, op.addr & 32'hFFFF_FFFC, modelBe(op)); end
                if (op.write) begin
                    total++; if (o.wdata !== modelWdata(op) || o.dv !== 1'b0 || o.readyAfter !== 1'b1) begin bad++; $display("FAIL rnd%0d_store wdata=%h dv=%b ready=%b exp=%h/0/1", n, o.wdata, o.dv, o.readyAfter, modelWdata(op)); end
                end else begin
                    total++; if (o.dv !== expDv || o.latency !== 3 + gd + rv || o.readyEnd !== 1'b1) begin bad++; $display("FAIL rnd%0d_load dv=%b lat=%0d ready=%b exp=%b/%0d/1", n, o.dv, o.latency, o.readyEnd, expDv, 3 + gd + rv); end
                    if (expDv) begin
                        total++; if (o.dvAddr !== op.rdAddr || o.dvData !== modelLoad(op, rdata)) begin bad++; $display("FAIL rnd%0d_wb addr=%0d data=%h exp=%0d/%h", n, o.dvAddr, o.dvData, op.rdAddr, modelLoad(op, rdata)); end
                    end
                end
                total++; if (o.stable !== 1'b1 || o.reqDropped !== 1'b1 || o.earlyDv !== 1'b0 || o.dvAfter !== 1'b0) begin bad++; $display("FAIL rnd%0d_hs stable=%b dropped=%b early=%b dvAfter=%b exp=1/1/0/0", n, o.stable, o.reqDropped, o.earlyDv, o.dvAfter); end
            end else begin
                total++; if (o.readyAt !== 1'b1) begin bad++; $display("FAIL rnd%0d_noaccess_ready got=%b exp=1", n, o.readyAt); end
            end
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b0;
        bus.iMemValid   = 1'b0;
        bus.iMemOp      = '0;
        bus.iDmemGnt    = 1'b0;
        bus.iDmemRvalid = 1'b0;
        bus.iDmemRdata  = '0;

        test_reset();
        test_store_word();
        test_store_lanes();
        test_load_byte();
        test_load_half_unsigned();
        test_fault();
        test_drop();
        test_gnt_stall();
        test_rd_zero();
        test_reset_in_wait();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
